// File: rtl/uart_pkg.sv
// Shared types for the UART transmit scheduler: FSM states, byte source tags and data width.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } uart_tx_sched_state_e;

  typedef enum logic {
    SRC_FIFO,
    SRC_XCHAR
  } uart_tx_src_e;

endpackage

// File: rtl/uart_tx_sched_if.sv
// Scheduler <-> uart_tx byte handshake plus the out-of-band flow-control character request.
// Handshake: uart_tx_data is stable while uart_tx_data_rdy=1 and rdy never drops until the
// cycle uart_tx_data_ack=1; the byte is transferred in that cycle. xchar_req is a level held
// by the requester until xchar_ack pulses, which happens in the same cycle as the data ack.
interface uart_tx_sched_if;
  logic [7:0] uart_tx_data;
  logic       uart_tx_data_rdy;
  logic       uart_tx_data_ack;
  logic       uart_tx_idle;
  logic [7:0] xchar;
  logic       xchar_req;
  logic       xchar_ack;

  modport master (
    output uart_tx_data, uart_tx_data_rdy, xchar_ack,
    input  uart_tx_data_ack, uart_tx_idle, xchar, xchar_req
  );

  modport slave (
    input  uart_tx_data, uart_tx_data_rdy, xchar_ack,
    output uart_tx_data_ack, uart_tx_idle, xchar, xchar_req
  );
endinterface

// File: rtl/uart_fifo.sv
// Synchronous FIFO with flush; single_i restricts it to one entry (slot 0) for non-FIFO mode.
module uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     single_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   cnt_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]    waddr, raddr;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = single_i ? (cnt_q != '0) : (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;

  // A flush in the same cycle as a write discards the write.
  assign do_push = push_i && !full_o && !clr_i;
  assign do_pop  = pop_i && !empty_o;

  assign waddr   = single_i ? '0 : wr_ptr_q;
  assign raddr   = single_i ? '0 : rd_ptr_q;
  assign rdata_o = mem[raddr];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[waddr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_sched.sv
// Transmit scheduler: TX FIFO plus XON/XOFF injection with strict priority, CTS auto flow
// control on FIFO data only, and a registered rdy/ack offer towards uart_tx.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uart_tx_en_i,
  input  logic                   fifo_en_i,
  input  logic                   fifo_clr_i,
  input  logic                   afc_en_i,
  input  logic                   cts_i,
  input  logic [7:0]             wr_data_i,
  input  logic                   wr_en_i,
  uart_tx_sched_if.master        tx,
  output logic [$clog2(DEPTH):0] fifo_cnt_o,
  output logic                   fifo_full_o,
  output logic                   overrun_o,
  output logic                   temt_o,
  output uart_tx_sched_state_e   state_o
);
  uart_tx_sched_state_e state_q, state_d;
  uart_tx_src_e         src_q, src_d;
  logic [BYTE_W-1:0]    hold_q, hold_d;
  logic [BYTE_W-1:0]    fifo_rdata;
  logic                 fifo_empty, fifo_pop;

  uart_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .single_i (!fifo_en_i),
    .clr_i    (fifo_clr_i),
    .push_i   (wr_en_i),
    .wdata_i  (wr_data_i),
    .pop_i    (fifo_pop),
    .rdata_o  (fifo_rdata),
    .cnt_o    (fifo_cnt_o),
    .full_o   (fifo_full_o),
    .empty_o  (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      src_q   <= SRC_FIFO;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      hold_q  <= hold_d;
    end
  end

  // Once an offer is made it stays up until acked, whatever happens to enable or CTS.
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (uart_tx_en_i) begin
          if (tx.xchar_req) begin
            hold_d  = tx.xchar;
            src_d   = SRC_XCHAR;
            state_d = S_OFFER;
          end else if (!fifo_empty && (!afc_en_i || cts_i)) begin
            hold_d   = fifo_rdata;
            src_d    = SRC_FIFO;
            fifo_pop = 1'b1;
            state_d  = S_OFFER;
          end
        end
      end
      S_OFFER: begin
        if (tx.uart_tx_data_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx.uart_tx_data     = hold_q;
  assign tx.uart_tx_data_rdy = (state_q == S_OFFER);
  assign tx.xchar_ack        = (state_q == S_OFFER) && tx.uart_tx_data_ack && (src_q == SRC_XCHAR);

  assign overrun_o = wr_en_i && fifo_full_o && !fifo_clr_i;
  assign temt_o    = (state_q == S_IDLE) && fifo_empty && !tx.xchar_req && tx.uart_tx_idle;
  assign state_o   = state_q;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a uart_tx responder model, an expected-byte queue and a
// monitor that checks every acked byte and its xchar_ack flag against that queue.
module tb_uart_tx_sched;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int FRAME = 8;

  logic                   clk = 1'b0;
  logic                   rst_i;
  logic                   uart_tx_en_i, fifo_en_i, fifo_clr_i, afc_en_i, cts_i;
  logic [7:0]             wr_data_i;
  logic                   wr_en_i;
  logic [$clog2(DEPTH):0] fifo_cnt_o;
  logic                   fifo_full_o, overrun_o, temt_o;
  uart_tx_sched_state_e   state_o;

  uart_tx_sched_if bus();

  int         total = 0;
  int         bad = 0;
  int         ovr_cnt = 0;
  bit         resp_en = 1'b0;
  logic [8:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  uart_tx_sched #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .uart_tx_en_i (uart_tx_en_i),
    .fifo_en_i    (fifo_en_i),
    .fifo_clr_i   (fifo_clr_i),
    .afc_en_i     (afc_en_i),
    .cts_i        (cts_i),
    .wr_data_i    (wr_data_i),
    .wr_en_i      (wr_en_i),
    .tx           (bus),
    .fifo_cnt_o   (fifo_cnt_o),
    .fifo_full_o  (fifo_full_o),
    .overrun_o    (overrun_o),
    .temt_o       (temt_o),
    .state_o      (state_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] d);
    wr_data_i = d;
    wr_en_i   = 1'b1;
    tick(1);
    wr_en_i   = 1'b0;
  endtask

  task automatic push_exp(input logic is_x, input logic [7:0] d);
    exp_q.push_back({is_x, d});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // uart_tx model: accepts only when idle, then stays busy for a frame
  initial begin
    bus.uart_tx_data_ack = 1'b0;
    bus.uart_tx_idle     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rst_i) begin
        bus.uart_tx_data_ack = 1'b0;
        bus.uart_tx_idle     = 1'b1;
      end else if (resp_en && bus.uart_tx_data_rdy && bus.uart_tx_idle) begin
        bus.uart_tx_data_ack = 1'b1;
        bus.uart_tx_idle     = 1'b0;
        @(posedge clk);
        #1;
        bus.uart_tx_data_ack = 1'b0;
        repeat (FRAME) @(posedge clk);
        #1;
        bus.uart_tx_idle = 1'b1;
      end
    end
  end

  // monitor / scoreboard
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (overrun_o) ovr_cnt++;
      if (bus.uart_tx_data_rdy && bus.uart_tx_data_ack) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h expected none", bus.uart_tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", int'(bus.uart_tx_data), int'(e[7:0]));
          chk("xchar_ack", int'(bus.xchar_ack), int'(e[8]));
        end
      end
      if (bus.xchar_ack) bus.xchar_req = 1'b0;
    end
  end

  initial begin
    int ovr0;
    int n;
    rst_i = 1'b1; uart_tx_en_i = 1'b0; fifo_en_i = 1'b1; fifo_clr_i = 1'b0;
    afc_en_i = 1'b0; cts_i = 1'b1; wr_data_i = 8'h00; wr_en_i = 1'b0;
    bus.xchar = 8'h00; bus.xchar_req = 1'b0;
    tick(2);
    chk("rst_rdy", int'(bus.uart_tx_data_rdy), 0);
    chk("rst_data", int'(bus.uart_tx_data), 0);
    chk("rst_cnt", int'(fifo_cnt_o), 0);
    chk("rst_full", int'(fifo_full_o), 0);
    chk("rst_temt", int'(temt_o), 1);
    chk("rst_state", int'(state_o), int'(S_IDLE));
    chk("rst_xack", int'(bus.xchar_ack), 0);
    chk("rst_ovr", int'(overrun_o), 0);
    rst_i = 1'b0;

    // 1: single byte, registered selection latency
    uart_tx_en_i = 1'b1; resp_en = 1'b1;
    push_exp(1'b0, 8'hA5);
    wr_byte(8'hA5);
    chk("t1_rdy_early", int'(bus.uart_tx_data_rdy), 0);
    tick(1);
    chk("t1_rdy", int'(bus.uart_tx_data_rdy), 1);
    chk("t1_data", int'(bus.uart_tx_data), 8'hA5);
    wait_drain("t1_drain", 20);
    n = 0;
    while (!temt_o && n < 50) begin tick(1); n++; end
    chk("t1_temt", int'(temt_o), 1);

    // 2: fill FIFO with tx disabled, 17th write overruns
    uart_tx_en_i = 1'b0;
    ovr0 = ovr_cnt;
    for (int i = 0; i < 17; i++) begin
      wr_data_i = 8'(8'h10 + i);
      wr_en_i   = 1'b1;
      tick(1);
    end
    wr_en_i = 1'b0;
    tick(1);
    chk("t2_cnt", int'(fifo_cnt_o), 16);
    chk("t2_full", int'(fifo_full_o), 1);
    chk("t2_ovr", ovr_cnt - ovr0, 1);
    for (int i = 0; i < 16; i++) push_exp(1'b0, 8'(8'h10 + i));
    uart_tx_en_i = 1'b1;
    wait_drain("t2_drain", 400);
    chk("t2_cnt_after", int'(fifo_cnt_o), 0);

    // 3: xchar jumps ahead of queued bytes
    uart_tx_en_i = 1'b0;
    wr_byte(8'h31); wr_byte(8'h32); wr_byte(8'h33);
    bus.xchar = 8'h13; bus.xchar_req = 1'b1;
    push_exp(1'b1, 8'h13);
    push_exp(1'b0, 8'h31); push_exp(1'b0, 8'h32); push_exp(1'b0, 8'h33);
    tick(1);
    uart_tx_en_i = 1'b1;
    wait_drain("t3_drain", 200);

    // 4: CTS low blocks FIFO data but not xchar
    afc_en_i = 1'b1; cts_i = 1'b0;
    wr_byte(8'h41); wr_byte(8'h42);
    tick(5);
    chk("t4_no_rdy", int'(bus.uart_tx_data_rdy), 0);
    chk("t4_cnt", int'(fifo_cnt_o), 2);
    bus.xchar = 8'h11; bus.xchar_req = 1'b1;
    push_exp(1'b1, 8'h11);
    wait_drain("t4_xdrain", 100);
    chk("t4_cnt_hold", int'(fifo_cnt_o), 2);
    push_exp(1'b0, 8'h41); push_exp(1'b0, 8'h42);
    cts_i = 1'b1;
    wait_drain("t4_drain", 200);
    afc_en_i = 1'b0;
    tick(FRAME + 2);

    // 5: flush while 8'h55 is on offer
    resp_en = 1'b0;
    wr_byte(8'h55); wr_byte(8'h66); wr_byte(8'h77);
    chk("t5_rdy", int'(bus.uart_tx_data_rdy), 1);
    chk("t5_data", int'(bus.uart_tx_data), 8'h55);
    chk("t5_cnt_pre", int'(fifo_cnt_o), 2);
    fifo_clr_i = 1'b1;
    tick(1);
    fifo_clr_i = 1'b0;
    chk("t5_cnt_clr", int'(fifo_cnt_o), 0);
    chk("t5_data_kept", int'(bus.uart_tx_data), 8'h55);
    push_exp(1'b0, 8'h55);
    resp_en = 1'b1;
    wait_drain("t5_drain", 100);
    tick(20);
    chk("t5_no_rdy", int'(bus.uart_tx_data_rdy), 0);
    uart_tx_en_i = 1'b0;
    ovr0 = ovr_cnt;
    fifo_clr_i = 1'b1; wr_data_i = 8'h99; wr_en_i = 1'b1;
    tick(1);
    fifo_clr_i = 1'b0; wr_en_i = 1'b0;
    chk("t5_clr_wr_cnt", int'(fifo_cnt_o), 0);
    chk("t5_clr_wr_ovr", ovr_cnt - ovr0, 0);

    // 6: reset with an offer in flight and bytes queued
    resp_en = 1'b0;
    wr_byte(8'hA1); wr_byte(8'hA2); wr_byte(8'hA3); wr_byte(8'hA4);
    chk("t6_cnt", int'(fifo_cnt_o), 4);
    uart_tx_en_i = 1'b1;
    tick(2);
    chk("t6_rdy", int'(bus.uart_tx_data_rdy), 1);
    chk("t6_data", int'(bus.uart_tx_data), 8'hA1);
    rst_i = 1'b1;
    tick(1);
    chk("t6_rst_rdy", int'(bus.uart_tx_data_rdy), 0);
    chk("t6_rst_cnt", int'(fifo_cnt_o), 0);
    chk("t6_rst_state", int'(state_o), int'(S_IDLE));
    chk("t6_rst_data", int'(bus.uart_tx_data), 0);
    rst_i = 1'b0;
    tick(3);
    chk("t6_after_rdy", int'(bus.uart_tx_data_rdy), 0);

    // 7: single-entry mode
    uart_tx_en_i = 1'b0; fifo_en_i = 1'b0;
    ovr0 = ovr_cnt;
    wr_byte(8'hB1); wr_byte(8'hB2);
    chk("t7_cnt", int'(fifo_cnt_o), 1);
    chk("t7_full", int'(fifo_full_o), 1);
    chk("t7_ovr", ovr_cnt - ovr0, 1);
    push_exp(1'b0, 8'hB1);
    uart_tx_en_i = 1'b1; resp_en = 1'b1;
    wait_drain("t7_drain", 50);
    tick(FRAME + 4);
    chk("t7_temt", int'(temt_o), 1);
    chk("t7_cnt_after", int'(fifo_cnt_o), 0);

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
